key_entry_fsm: RTL

KEY_ENTRY_FSM -- requirements
Module: key_entry_fsm

---
 rtl/key_entry_fsm.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/key_entry_fsm.sv
// Calculator keypad entry controller: collects up to DIGITS BCD digits for two
// operands around an operator key and converts both to binary on '='.
module key_entry_fsm #(
  parameter int DIGITS = 3,
  parameter int W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            num,
  input  logic [3:0]            symbol,
  input  logic                  key,
  output logic [W-1:0]          src,
  output logic [W-1:0]          dst,
  output logic [7:0]            alu_op,
  output logic                  finish,
  output logic                  num_display,
  output logic [4*DIGITS-1:0]   digits_a,
  output logic [4*DIGITS-1:0]   digits_b,
  output logic [1:0]            state_dbg
);

  localparam int CW = (DIGITS < 2) ? 1 : $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

  localparam logic [3:0] SYM_DIGIT = 4'hF;
  localparam logic [3:0] SYM_EQ    = 4'h4;
  localparam logic [3:0] SYM_BS    = 4'h7;
  localparam logic [3:0] SYM_CLR   = 4'h8;

  typedef enum logic [1:0] {IDLE, FIRST, OPER, SECOND} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt_a, cnt_a_n, cnt_b, cnt_b_n;
  logic [4*DIGITS-1:0]   digits_a_n, digits_b_n;
  logic [W-1:0]          src_n, dst_n;
  logic [7:0]            alu_op_n;
  logic                  finish_n, num_display_n;

  logic key_q, key_armed, key_ev;
  logic is_digit, is_op;
  logic [7:0] op_code;

  function automatic logic [4*DIGITS-1:0] shift_in(input logic [4*DIGITS-1:0] x,
                                                    input logic [3:0] d);
    logic [4*DIGITS-1:0] r;
    r      = x << 4;
    r[3:0] = d;
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_to_bin(input logic [4*DIGITS-1:0] x);
    logic [W-1:0] acc;
    acc = '0;
    for (int i = DIGITS - 1; i >= 0; i--)
      acc = (acc << 3) + (acc << 1) + W'(x[4*i +: 4]);
    return acc;
  endfunction

  // key_armed blocks a key still held across reset until it is seen low once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q     <= 1'b0;
      key_armed <= 1'b0;
      key_ev    <= 1'b0;
    end else begin
      key_q  <= key;
      key_ev <= key & ~key_q & key_armed;
      if (!key) key_armed <= 1'b1;
    end
  end

  always_comb begin
    op_code = 8'h00;
    is_op   = 1'b1;
    case (symbol)
      4'h1:    op_code = 8'h01;
      4'h2:    op_code = 8'h02;
      4'h3:    op_code = 8'h04;
      4'h5:    op_code = 8'h08;
      4'h6:    op_code = 8'h10;
      default: is_op   = 1'b0;
    endcase
    is_digit = (symbol == SYM_DIGIT) && (num <= 4'd9);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt_a       <= '0;
      cnt_b       <= '0;
      digits_a    <= '0;
      digits_b    <= '0;
      src         <= '0;
      dst         <= '0;
      alu_op      <= 8'h00;
      finish      <= 1'b0;
      num_display <= 1'b0;
    end else begin
      state       <= state_n;
      cnt_a       <= cnt_a_n;
      cnt_b       <= cnt_b_n;
      digits_a    <= digits_a_n;
      digits_b    <= digits_b_n;
      src         <= src_n;
      dst         <= dst_n;
      alu_op      <= alu_op_n;
      finish      <= finish_n;
      num_display <= num_display_n;
    end
  end

  // finish is a one-cycle valid strobe for src/dst/alu_op; there is no ready,
  // the consumer must capture the result in the cycle finish is high.
  always_comb begin
    state_n       = state;
    cnt_a_n       = cnt_a;
    cnt_b_n       = cnt_b;
    digits_a_n    = digits_a;
    digits_b_n    = digits_b;
    src_n         = src;
    dst_n         = dst;
    alu_op_n      = alu_op;
    finish_n      = 1'b0;
    num_display_n = num_display;

    if (key_ev) begin
      if (symbol == SYM_CLR) begin
        state_n       = IDLE;
        cnt_a_n       = '0;
        cnt_b_n       = '0;
        digits_a_n    = '0;
        digits_b_n    = '0;
        alu_op_n      = 8'h00;
        num_display_n = 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (is_digit) begin
              digits_a_n    = shift_in('0, num);
              digits_b_n    = '0;
              alu_op_n      = 8'h00;
              cnt_a_n       = CNT_ONE;
              cnt_b_n       = '0;
              num_display_n = 1'b0;
              state_n       = FIRST;
            end
          end
          FIRST: begin
            if (is_digit) begin
              if (cnt_a < CNT_MAX) begin
                digits_a_n = shift_in(digits_a, num);
                cnt_a_n    = cnt_a + CNT_ONE;
              end
            end else if (is_op) begin
              alu_op_n = op_code;
              state_n  = OPER;
            end else if (symbol == SYM_BS) begin
              digits_a_n = digits_a >> 4;
              cnt_a_n    = cnt_a - CNT_ONE;
              if (cnt_a == CNT_ONE) state_n = IDLE;
            end
          end
          OPER: begin
            if (is_op) begin
              alu_op_n = op_code;
            end else if (symbol == SYM_BS) begin
              alu_op_n = 8'h00;
              state_n  = FIRST;
            end else if (is_digit) begin
              digits_b_n    = shift_in('0, num);
              cnt_b_n       = CNT_ONE;
              num_display_n = 1'b1;
              state_n       = SECOND;
            end
          end
          SECOND: begin
            if (is_digit) begin
              if (cnt_b < CNT_MAX) begin
                digits_b_n = shift_in(digits_b, num);
                cnt_b_n    = cnt_b + CNT_ONE;
              end
            end else if (symbol == SYM_BS) begin
              digits_b_n = digits_b >> 4;
              cnt_b_n    = cnt_b - CNT_ONE;
              if (cnt_b == CNT_ONE) begin
                num_display_n = 1'b0;
                state_n       = OPER;
              end
            end else if (symbol == SYM_EQ) begin
              src_n    = bcd_to_bin(digits_a);
              dst_n    = bcd_to_bin(digits_b);
              finish_n = 1'b1;
              state_n  = IDLE;
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  assign state_dbg = state;

endmodule
